instruction_encoder: RTL and testbench

//  Reverse of the IR decode path: packs opcode/register/immediate/target fields into 16-bit instruction

---
 rtl/instruction_encoder_pkg.sv | 66 ++++++
 rtl/instruction_encoder_fifo.sv | 52 +++++
 rtl/instruction_encoder.sv | 149 ++++++++++++++
 tb/tb_instruction_encoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_encoder_pkg.sv
// rtl/instruction_encoder_pkg.sv - shared formats, field positions and FSM states for the instruction encoder
package instruction_encoder_pkg;

    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_J   = 2'd2;
    localparam logic [1:0] FMT_BAD = 2'd3;

    localparam int WORD_W    = 16;
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int RS_MSB    = 11;
    localparam int RS_LSB    = 10;
    localparam int RT_MSB    = 9;
    localparam int RT_LSB    = 8;
    localparam int RD_MSB    = 7;
    localparam int RD_LSB    = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 7;
    localparam int IMM_LSB   = 0;
    localparam int TGT_MSB   = 11;
    localparam int TGT_LSB   = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

    // Inverse of the decoder's field extraction; an illegal format yields zero.
    function automatic logic [WORD_W-1:0] encode_word(
        input logic [1:0]  fmt,
        input logic [3:0]  opcode,
        input logic [1:0]  rs,
        input logic [1:0]  rt,
        input logic [1:0]  rd,
        input logic [5:0]  funct,
        input logic [7:0]  imm,
        input logic [11:0] target
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[OPC_MSB:OPC_LSB] = opcode;
        case (fmt)
            FMT_R: begin
                w[RS_MSB:RS_LSB]       = rs;
                w[RT_MSB:RT_LSB]       = rt;
                w[RD_MSB:RD_LSB]       = rd;
                w[FUNCT_MSB:FUNCT_LSB] = funct;
            end
            FMT_I: begin
                w[RS_MSB:RS_LSB]   = rs;
                w[RT_MSB:RT_LSB]   = rt;
                w[IMM_MSB:IMM_LSB] = imm;
            end
            FMT_J: begin
                w[TGT_MSB:TGT_LSB] = target;
            end
            default: begin
                w = '0;
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instruction_encoder_fifo.sv
// rtl/instruction_encoder_fifo.sv - DEPTH x WIDTH synchronous FIFO holding encoded words
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs instruction fields, queues them and writes them to instruction memory
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [3:0]        opcode,
    input  logic [1:0]        rs,
    input  logic [1:0]        rt,
    input  logic [1:0]        rd,
    input  logic [5:0]        funct,
    input  logic [7:0]        immediate,
    input  logic [11:0]       target,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] wr_count,
    output logic              err,
    input  logic              err_clr
);

    wr_state_e         r_state;
    wr_state_e         w_state_nxt;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_wr_count;
    logic              r_err;

    logic              w_accept;
    logic              w_push;
    logic              w_illegal;
    logic [15:0]       w_word;
    logic [15:0]       w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_launch;
    logic              w_pop;
    logic              w_base_take;

    assign in_ready  = ~w_full;
    assign w_accept  = in_valid & in_ready;
    assign w_illegal = w_accept & (fmt == FMT_BAD);
    assign w_push    = w_accept & (fmt != FMT_BAD);
    assign w_word    = encode_word(fmt, opcode, rs, rt, rd, funct, immediate, target);

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // mem_we is always low in IDLE, so a base load there never disturbs a write.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_pop       = 1'b0;
        w_base_take = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (base_load) begin
                    w_base_take = 1'b1;
                end else if (!w_empty) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wptr      <= '0;
            r_wr_count  <= '0;
        end else begin
            if (w_launch) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_wptr;
                r_mem_wdata <= w_head;
            end
            if (w_pop) begin
                r_mem_we   <= 1'b0;
                r_wptr     <= r_wptr + ADDR_W'(1);
                r_wr_count <= r_wr_count + ADDR_W'(1);
            end
            if (w_base_take) begin
                r_wptr     <= base_addr;
                r_wr_count <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign wr_count  = r_wr_count;
    assign err       = r_err;
    assign busy      = (r_state != ST_IDLE) | ~w_empty;

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - directed self-checking bench for instruction_encoder
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [3:0]  opcode;
    logic [1:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [7:0]  immediate;
    logic [11:0] target;
    logic        base_load;
    logic [7:0]  base_addr;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic        busy;
    logic [7:0]  wr_count;
    logic        err;
    logic        err_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .funct     (funct),
        .immediate (immediate),
        .target    (target),
        .base_load (base_load),
        .base_addr (base_addr),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .wr_count  (wr_count),
        .err       (err),
        .err_clr   (err_clr)
    );

    task automatic drive_bundle(input logic [1:0] f, input logic [3:0] op, input logic [1:0] s,
                                input logic [1:0] t, input logic [1:0] d, input logic [5:0] fn,
                                input logic [7:0] im, input logic [11:0] tg);
        @(negedge clk);
        fmt = f; opcode = op; rs = s; rt = t; rd = d; funct = fn; immediate = im; target = tg;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_base(input logic [7:0] a);
        @(negedge clk);
        base_addr = a;
        base_load = 1'b1;
        @(negedge clk);
        base_load = 1'b0;
    endtask

    task automatic wait_we(output logic ok, output logic [7:0] a, output logic [15:0] d);
        ok = 1'b0; a = '0; d = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_we) begin
                ok = 1'b1; a = mem_addr; d = mem_wdata;
                break;
            end
        end
    endtask

    task automatic ack_write;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        in_valid = 0; fmt = 0; opcode = 0; rs = 0; rt = 0; rd = 0; funct = 0;
        immediate = 0; target = 0; base_load = 0; base_addr = 0; mem_ack = 0; err_clr = 0;
        repeat (2) @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
        checks++; if (mem_wdata !== 16'h0000) begin failures++; $display("FAIL reset_wdata: got %h expected 0000", mem_wdata); end
        checks++; if (wr_count !== 8'h00) begin failures++; $display("FAIL reset_count: got %h expected 00", wr_count); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        reset_n = 1'b1;
    endtask

    task automatic test_r_and_i;
        logic ok; logic [7:0] a; logic [15:0] d;
        load_base(8'h10);
        drive_bundle(2'd0, 4'd1, 2'd1, 2'd2, 2'd3, 6'd0, 8'h00, 12'h000);
        wait_we(ok, a, d);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL r_timeout: got %b expected 1", ok); end
        checks++; if (a !== 8'h10) begin failures++; $display("FAIL r_addr: got %h expected 10", a); end
        checks++; if (d !== 16'h16C0) begin failures++; $display("FAIL r_wdata: got %h expected 16c0", d); end
        ack_write();
        drive_bundle(2'd1, 4'd5, 2'd0, 2'd1, 2'd0, 6'd0, 8'hA5, 12'h000);
        wait_we(ok, a, d);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL i_timeout: got %b expected 1", ok); end
        checks++; if (a !== 8'h11) begin failures++; $display("FAIL i_addr: got %h expected 11", a); end
        checks++; if (d !== 16'h51A5) begin failures++; $display("FAIL i_wdata: got %h expected 51a5", d); end
        ack_write();
        checks++; if (wr_count !== 8'd2) begin failures++; $display("FAIL ri_count: got %h expected 02", wr_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ri_busy: got %b expected 0", busy); end
    endtask

    task automatic test_j_base_ignored;
        logic ok; logic [7:0] a; logic [15:0] d;
        drive_bundle(2'd2, 4'hC, 2'd0, 2'd0, 2'd0, 6'd0, 8'h00, 12'h3FF);
        wait_we(ok, a, d);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL j_timeout: got %b expected 1", ok); end
        checks++; if (a !== 8'h12) begin failures++; $display("FAIL j_addr: got %h expected 12", a); end
        checks++; if (d !== 16'hC3FF) begin failures++; $display("FAIL j_wdata: got %h expected c3ff", d); end
        base_addr = 8'h40; base_load = 1'b1;
        @(negedge clk);
        base_load = 1'b0;
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL j_hold_we: got %b expected 1", mem_we); end
        checks++; if (mem_addr !== 8'h12) begin failures++; $display("FAIL j_hold_addr: got %h expected 12", mem_addr); end
        ack_write();
        checks++; if (wr_count !== 8'd3) begin failures++; $display("FAIL j_count: got %h expected 03", wr_count); end
        drive_bundle(2'd0, 4'd2, 2'd3, 2'd0, 2'd1, 6'h2A, 8'h00, 12'h000);
        wait_we(ok, a, d);
        checks++; if (a !== 8'h13) begin failures++; $display("FAIL nobase_addr: got %h expected 13", a); end
        checks++; if (d !== 16'h2C6A) begin failures++; $display("FAIL nobase_wdata: got %h expected 2c6a", d); end
        ack_write();
    endtask

    task automatic test_full;
        logic ok; logic [7:0] a; logic [15:0] d;
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_bundle(2'd2, 4'h9, 2'd0, 2'd0, 2'd0, 6'd0, 8'h00, 12'(i + 1));
        end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %b expected 0", in_ready); end
        drive_bundle(2'd2, 4'h9, 2'd0, 2'd0, 2'd0, 6'd0, 8'h00, 12'h005);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready5: got %b expected 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            wait_we(ok, a, d);
            checks++; if (ok !== 1'b1) begin failures++; $display("FAIL drain_timeout[%0d]: got %b expected 1", i, ok); end
            checks++; if (a !== 8'(8'h14 + i)) begin failures++; $display("FAIL drain_addr[%0d]: got %h expected %h", i, a, 8'(8'h14 + i)); end
            checks++; if (d !== 16'(16'h9001 + i)) begin failures++; $display("FAIL drain_wdata[%0d]: got %h expected %h", i, d, 16'(16'h9001 + i)); end
            ack_write();
        end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL drain_ready: got %b expected 1", in_ready); end
        checks++; if (wr_count !== 8'd8) begin failures++; $display("FAIL drain_count: got %h expected 08", wr_count); end
        repeat (5) @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL fifth_written: got %b expected 0", mem_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_write;
        logic ok; logic [7:0] a; logic [15:0] d;
        drive_bundle(2'd1, 4'h3, 2'd1, 2'd1, 2'd0, 6'd0, 8'h77, 12'h000);
        wait_we(ok, a, d);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mid_timeout: got %b expected 1", ok); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL mid_we: got %b expected 0", mem_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (wr_count !== 8'h00) begin failures++; $display("FAIL mid_count: got %h expected 00", wr_count); end
        checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL mid_addr: got %h expected 00", mem_addr); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_illegal;
        drive_bundle(2'd3, 4'hF, 2'd3, 2'd3, 2'd3, 6'h3F, 8'hFF, 12'hFFF);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err: got %b expected 1", err); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL ill_we: got %b expected 0", mem_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ill_busy: got %b expected 0", busy); end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL clr_err: got %b expected 0", err); end
        err_clr = 1'b1; fmt = 2'd3; in_valid = 1'b1;
        @(negedge clk);
        err_clr = 1'b0; in_valid = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL clr_priority: got %b expected 0", err); end
        checks++; if (wr_count !== 8'h00) begin failures++; $display("FAIL ill_count: got %h expected 00", wr_count); end
    endtask

    task automatic test_wrap;
        logic ok; logic [7:0] a; logic [15:0] d;
        load_base(8'hFF);
        drive_bundle(2'd1, 4'h3, 2'd2, 2'd3, 2'd0, 6'd0, 8'h0F, 12'h000);
        wait_we(ok, a, d);
        checks++; if (a !== 8'hFF) begin failures++; $display("FAIL wrap_addr0: got %h expected ff", a); end
        checks++; if (d !== 16'h3B0F) begin failures++; $display("FAIL wrap_wdata0: got %h expected 3b0f", d); end
        ack_write();
        drive_bundle(2'd1, 4'h7, 2'd1, 2'd0, 2'd0, 6'd0, 8'hFF, 12'h000);
        wait_we(ok, a, d);
        checks++; if (a !== 8'h00) begin failures++; $display("FAIL wrap_addr1: got %h expected 00", a); end
        checks++; if (d !== 16'h74FF) begin failures++; $display("FAIL wrap_wdata1: got %h expected 74ff", d); end
        ack_write();
        checks++; if (wr_count !== 8'd2) begin failures++; $display("FAIL wrap_count: got %h expected 02", wr_count); end
    endtask

    initial begin
        test_reset();
        test_r_and_i();
        test_j_base_ignored();
        test_full();
        test_reset_mid_write();
        test_illegal();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
